// File: rtl/topk_tracker_if.sv
// Bus bundle for topk_tracker: sample stream, flush, rank select and readback.
// The master side (producer/reader) drives flush, din_valid, din and sel; the
// slave side (the tracker) returns dout, count and full.
interface topk_tracker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
);
    localparam int SEL_W = ($clog2(K) > 1) ? $clog2(K) : 1;
    localparam int CNT_W = $clog2(K + 1);

    logic                  flush;
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] dout;
    logic [CNT_W-1:0]      count;
    logic                  full;

    modport master (
        output flush, din_valid, din, sel,
        input  dout, count, full
    );

    modport slave (
        input  flush, din_valid, din, sel,
        output dout, count, full
    );
endinterface

// File: rtl/topk_tracker.sv
// topk_tracker: keeps the K largest unsigned samples seen since reset/flush as a
// sorted (non-increasing) register array, readable by rank through sel.
// Optional macro TOPK_DISTINCT_EN: when defined, a sample equal to any valid
// entry is dropped so the ranks hold distinct values.
module topk_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) (
    input  logic           clk,
    input  logic           resetn,
    topk_tracker_if.slave  bus
);
    localparam int SEL_W = ($clog2(K) > 1) ? $clog2(K) : 1;
    localparam int CNT_W = $clog2(K + 1);

    logic [DATA_WIDTH-1:0] r_top [K];
    logic [CNT_W-1:0]      r_count;

    // w_valid: slot holds a real sample. w_gt: din belongs at or above this slot
    // (invalid slots act as minus infinity). Because the array is sorted, w_gt is
    // 0..0 then 1..1, so the first set bit is the insert position.
    logic [K-1:0]          w_valid;
    logic [K-1:0]          w_gt;
    logic [K-1:0]          w_hit;
    logic [DATA_WIDTH-1:0] w_top_ins [K];
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_dup;
    logic                  w_insert;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            assign w_valid[gi] = (CNT_W'(gi) < r_count);
            // Strict greater-than: an equal value lands below the existing entry.
            assign w_gt[gi]    = !w_valid[gi] || (bus.din > r_top[gi]);
            assign w_hit[gi]   = w_valid[gi] && (bus.sel == SEL_W'(gi));
            if (gi == 0) begin : g_first
                assign w_top_ins[gi] = w_gt[gi] ? bus.din : r_top[gi];
            end else begin : g_rest
                // Slot at the insert position takes din; slots below it take
                // their upper neighbour (shift down by one).
                assign w_top_ins[gi] = !w_gt[gi]     ? r_top[gi]
                                     : w_gt[gi-1]    ? r_top[gi-1]
                                     :                 bus.din;
            end
        end
    endgenerate

`ifdef TOPK_DISTINCT_EN
    logic [K-1:0] w_eq;
    generate
        for (gi = 0; gi < K; gi++) begin : g_eq
            assign w_eq[gi] = w_valid[gi] && (bus.din == r_top[gi]);
        end
    endgenerate
    assign w_dup = |w_eq;
`else
    assign w_dup = 1'b0;
`endif

    // If the lowest slot is not displaced, no slot is, so nothing is inserted.
    assign w_insert = bus.din_valid && w_gt[K-1] && !w_dup;

    // State update: reset beats flush beats insert; flush with valid seeds one entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < K; i++) r_top[i] <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < K; i++) r_top[i] <= '0;
            if (bus.din_valid) begin
                r_top[0] <= bus.din;
                r_count  <= CNT_W'(1);
            end else begin
                r_count  <= '0;
            end
        end else if (w_insert) begin
            for (int i = 0; i < K; i++) r_top[i] <= w_top_ins[i];
            if (r_count != CNT_W'(K)) r_count <= r_count + CNT_W'(1);
        end
    end

    // Rank readback: combinational mux on sel; unselected or invalid ranks read 0.
    always_comb begin
        w_dout = '0;
        for (int i = 0; i < K; i++) begin
            if (w_hit[i]) w_dout = r_top[i];
        end
    end

    assign bus.dout  = w_dout;
    assign bus.count = r_count;
    assign bus.full  = (r_count == CNT_W'(K));

endmodule

// File: tb/tb_topk_tracker.sv
// Self-checking bench for topk_tracker: a sorted-queue reference model of the
// K largest samples, a per-cycle compare process, directed scenarios with
// literal expectations, then randomized streams with flushes and resets.
module tb_topk_tracker;
    localparam int DW    = 32;
    localparam int K     = 4;
    localparam int SEL_W = ($clog2(K) > 1) ? $clog2(K) : 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    topk_tracker_if #(.DATA_WIDTH(DW), .K(K)) bus ();

    topk_tracker #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference: the K largest accepted samples, largest first.
    logic [DW-1:0] q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_insert(input logic [DW-1:0] d);
        int p;
`ifdef TOPK_DISTINCT_EN
        foreach (q[i]) if (q[i] == d) return;
`endif
        p = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (d > q[i]) begin
                p = i;
                break;
            end
        end
        if (p < K) begin
            q.insert(p, d);
            if (q.size() > K) void'(q.pop_back());
        end
    endfunction

    function automatic logic [DW-1:0] exp_dout(input int s);
        return (s < q.size()) ? q[s] : '0;
    endfunction

    // Model update on the same edge the DUT samples.
    always @(posedge clk) begin
        if (!resetn) begin
            q.delete();
        end else if (bus.flush) begin
            q.delete();
            if (bus.din_valid) q.push_back(bus.din);
        end else if (bus.din_valid) begin
            model_insert(bus.din);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count", 64'(bus.count), 64'(q.size()));
            chk("cyc_full",  64'(bus.full),  64'(q.size() == K));
            chk("cyc_dout",  64'(bus.dout),  64'(exp_dout(int'(bus.sel))));
        end
    end

    // One transaction: apply inputs, let one edge pass, return 2 time units after it.
    task automatic cyc(input logic rn, input logic fl, input logic v, input logic [DW-1:0] d);
        resetn        = rn;
        bus.flush     = fl;
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        #2;
        $display("txn t=%0t resetn=%0b flush=%0b valid=%0b din=0x%0h -> count=%0d full=%0b",
                 $time, rn, fl, v, d, bus.count, bus.full);
        resetn        = 1'b1;
        bus.flush     = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    task automatic chk_sel(input string name, input int s, input logic [DW-1:0] exp);
        bus.sel = SEL_W'(s);
        #1;
        chk(name, 64'(bus.dout), 64'(exp));
    endtask

    initial begin
        resetn        = 1'b0;
        bus.flush     = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.sel       = '0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;

        // Reset state, with flush and a valid sample present (reset wins).
        cyc(1'b0, 1'b1, 1'b1, 32'd77);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_full",  64'(bus.full),  64'd0);
        chk_sel("rst_dout", 0, 32'd0);

        // First sample after reset.
        cyc(1'b1, 1'b0, 1'b1, 32'd5);
        chk("one_count", 64'(bus.count), 64'd1);
        chk("one_full",  64'(bus.full),  64'd0);
        chk_sel("one_sel0", 0, 32'd5);
        chk_sel("one_sel1", 1, 32'd0);

        // Fill and overflow.
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 32'd3);
        cyc(1'b1, 1'b0, 1'b1, 32'd9);
        cyc(1'b1, 1'b0, 1'b1, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'd7);
        cyc(1'b1, 1'b0, 1'b1, 32'd4);
        chk("fill_full", 64'(bus.full), 64'd1);
        chk_sel("fill_r0", 0, 32'd9);
        chk_sel("fill_r1", 1, 32'd7);
        chk_sel("fill_r2", 2, 32'd4);
        chk_sel("fill_r3", 3, 32'd3);
        cyc(1'b1, 1'b0, 1'b1, 32'd2);
        chk_sel("small_r3", 3, 32'd3);
        chk_sel("small_r0", 0, 32'd9);
        cyc(1'b1, 1'b0, 1'b1, 32'd8);
        chk_sel("ins8_r0", 0, 32'd9);
        chk_sel("ins8_r1", 1, 32'd8);
        chk_sel("ins8_r2", 2, 32'd7);
        chk_sel("ins8_r3", 3, 32'd4);

        // Duplicates.
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 32'd6);
        cyc(1'b1, 1'b0, 1'b1, 32'd6);
        cyc(1'b1, 1'b0, 1'b1, 32'd6);
`ifdef TOPK_DISTINCT_EN
        chk("dup_count", 64'(bus.count), 64'd1);
        chk_sel("dup_sel1", 1, 32'd0);
`else
        chk("dup_count", 64'(bus.count), 64'd3);
        chk_sel("dup_sel1", 1, 32'd6);
`endif

        // Zero and all-ones boundaries.
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 32'd0);
        chk("zero_count", 64'(bus.count), 64'd1);
        chk_sel("zero_sel0", 0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("max_count", 64'(bus.count), 64'd2);
        chk_sel("max_sel0", 0, 32'hFFFF_FFFF);
        chk_sel("max_sel1", 1, 32'd0);

        // Flush with a sample, then reset with the same inputs.
        cyc(1'b1, 1'b0, 1'b1, 32'd100);
        cyc(1'b1, 1'b0, 1'b1, 32'd50);
        cyc(1'b1, 1'b1, 1'b1, 32'd42);
        chk("flv_count", 64'(bus.count), 64'd1);
        chk_sel("flv_sel0", 0, 32'd42);
        chk_sel("flv_sel1", 1, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'd42);
        chk("rstflv_count", 64'(bus.count), 64'd0);
        chk_sel("rstflv_dout", 0, 32'd0);

        // Idle cycles with a wandering din hold state.
        cyc(1'b1, 1'b0, 1'b1, 32'd10);
        cyc(1'b1, 1'b0, 1'b1, 32'd20);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'($urandom));
        chk("idle_count", 64'(bus.count), 64'd2);
        chk_sel("idle_sel0", 0, 32'd20);
        chk_sel("idle_sel1", 1, 32'd10);

        // Randomized streams: narrow values force ties, wide values exercise
        // full-width compares; occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            logic rn, fl, v;
            logic [DW-1:0] d;
            rn = ($urandom_range(0, 199) != 0);
            fl = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            bus.sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            cyc(rn, fl, v, d);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
